// File: rtl/resource_arbiter.sv
// Round-robin arbiter for two requesters sharing a one-cycle doubling resource.
// Tagged results are steered back into per-requester response registers.
module resource_arbiter #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        req_valid,
  input  logic [DATA_W-1:0] req_data0,
  input  logic [DATA_W-1:0] req_data1,
  output logic [1:0]        req_ready,
  output logic [1:0]        stall,
  output logic [1:0]        rsp_valid,
  output logic [DATA_W-1:0] rsp_data0,
  output logic [DATA_W-1:0] rsp_data1,
  input  logic [1:0]        rsp_ready,
  output logic [1:0]        res_in_valid,
  output logic [DATA_W-1:0] res_in_data,
  input  logic [1:0]        res_out_valid,
  input  logic [DATA_W-1:0] res_out_data,
  output logic              err
);

  logic [1:0] inflight;
  logic       last;
  logic [1:0] eligible;
  logic [1:0] grant;
  logic [1:0] ret;
  logic       proto_err;

  // A draining response slot counts as free, so a requester can re-issue while its result is consumed.
  always_comb begin
    eligible = req_valid & ~inflight & (~rsp_valid | rsp_ready);
    grant    = 2'b00;
    if (!reset) begin
      case (eligible)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = last ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end

  always_comb begin
    req_ready    = grant;
    stall        = req_valid & ~grant;
    res_in_valid = grant;
    res_in_data  = '0;
    if (grant[0]) begin
      res_in_data = req_data0;
    end else if (grant[1]) begin
      res_in_data = req_data1;
    end
  end

  // Results are only accepted for requesters with an operation outstanding.
  always_comb begin
    ret       = res_out_valid & inflight;
    proto_err = (|(res_out_valid & ~inflight)) || (res_out_valid == 2'b11);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inflight  <= 2'b00;
      rsp_valid <= 2'b00;
      rsp_data0 <= '0;
      rsp_data1 <= '0;
      last      <= 1'b1;
      err       <= 1'b0;
    end else begin
      inflight  <= (inflight & ~ret) | grant;
      rsp_valid <= ret | (rsp_valid & ~rsp_ready);
      if (ret[0]) begin
        rsp_data0 <= res_out_data;
      end
      if (ret[1]) begin
        rsp_data1 <= res_out_data;
      end
      if (|grant) begin
        last <= grant[1];
      end
      if (proto_err) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_resource_arbiter.sv
// Self-checking bench for resource_arbiter: per-requester pending-result model
// plus a doubling resource model, compared against the DUT every cycle.
module tb_resource_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_valid;
  logic [31:0] req_data0, req_data1;
  logic [1:0]  req_ready, stall, rsp_valid, rsp_ready;
  logic [31:0] rsp_data0, rsp_data1;
  logic [1:0]  res_in_valid, res_out_valid;
  logic [31:0] res_in_data, res_out_data;
  logic        err;

  resource_arbiter #(.DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_data0(req_data0), .req_data1(req_data1),
    .req_ready(req_ready), .stall(stall),
    .rsp_valid(rsp_valid), .rsp_data0(rsp_data0), .rsp_data1(rsp_data1),
    .rsp_ready(rsp_ready),
    .res_in_valid(res_in_valid), .res_in_data(res_in_data),
    .res_out_valid(res_out_valid), .res_out_data(res_out_data),
    .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: each requester owns at most one pending result, visible from accept+2.
  int          now = 0;
  bit          m_has [2];
  int          m_ready_at [2];
  logic [31:0] m_val [2];
  logic [31:0] m_shown [2];
  int          m_prefer;
  bit          m_err;

  // What the DUT showed in the most recent tick, for literal checks.
  logic [1:0]  obs_ready, obs_stall, obs_rsp_valid, obs_res_in_valid, g_grant;
  logic [31:0] obs_res_in_data, obs_rsp_data0, obs_rsp_data1;
  logic        obs_err;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, now, act, exp);
    end
  endfunction

  task automatic tick();
    logic [1:0]  elig, grant, vis, infl, nxt_v;
    logic [31:0] opnd [2];
    logic [31:0] exp_data, nxt_d;
    int w;
    #1;
    opnd[0] = req_data0;
    opnd[1] = req_data1;
    if (reset) begin
      m_has[0] = 0; m_has[1] = 0;
      m_shown[0] = '0; m_shown[1] = '0;
      m_prefer = 0;
      m_err = 0;
    end
    for (int i = 0; i < 2; i++) begin
      vis[i]  = m_has[i] && (m_ready_at[i] <= now);
      infl[i] = m_has[i] && !vis[i];
      if (vis[i]) m_shown[i] = m_val[i];
      elig[i] = !reset && req_valid[i] && (!m_has[i] || (vis[i] && rsp_ready[i]));
    end
    w = -1;
    if (elig == 2'b11) w = m_prefer;
    else if (elig[0]) w = 0;
    else if (elig[1]) w = 1;
    grant = 2'b00;
    if (w >= 0) grant[w] = 1'b1;
    exp_data = (w >= 0) ? opnd[w] : 32'h0;

    chk("req_ready",    32'(req_ready),    32'(grant));
    chk("stall",        32'(stall),        32'(req_valid & ~grant));
    chk("res_in_valid", 32'(res_in_valid), 32'(grant));
    chk("res_in_data",  res_in_data,       exp_data);
    chk("rsp_valid",    32'(rsp_valid),    32'(vis));
    chk("rsp_data0",    rsp_data0,         m_shown[0]);
    chk("rsp_data1",    rsp_data1,         m_shown[1]);
    chk("err",          32'(err),          32'(m_err));

    obs_ready = req_ready; obs_stall = stall; obs_rsp_valid = rsp_valid;
    obs_res_in_valid = res_in_valid; obs_res_in_data = res_in_data;
    obs_rsp_data0 = rsp_data0; obs_rsp_data1 = rsp_data1; obs_err = err;
    g_grant = grant;

    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        if (vis[i] && rsp_ready[i]) m_has[i] = 0;
        if (res_out_valid[i] && !infl[i]) m_err = 1;
      end
      if (res_out_valid == 2'b11) m_err = 1;
      if (w >= 0) begin
        m_has[w]      = 1;
        m_val[w]      = opnd[w] << 1;
        m_ready_at[w] = now + 2;
        m_prefer      = 1 - w;
      end
    end

    // Doubling resource: answers the operand it saw, one cycle later.
    nxt_v = reset ? 2'b00 : res_in_valid;
    nxt_d = reset ? 32'h0 : (res_in_data << 1);
    @(posedge clk);
    now++;
    #1;
    res_out_valid = nxt_v;
    res_out_data  = nxt_d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int acc0;
    reset = 1'b0;
    req_valid = 2'b00; req_data0 = '0; req_data1 = '0;
    rsp_ready = 2'b11; res_out_valid = 2'b00; res_out_data = '0;
    #1 reset = 1'b1;

    // Reset values with requests pending.
    req_valid = 2'b11;
    tick();
    chk("rst_stall", 32'(obs_stall), 32'h3);
    chk("rst_res_in_valid", 32'(obs_res_in_valid), 32'h0);
    tick();

    // Single request: 5 -> 10 two cycles later.
    reset = 1'b0; req_valid = 2'b01; req_data0 = 32'd5;
    tick();
    chk("single_issue_tag", 32'(obs_res_in_valid), 32'h1);
    chk("single_issue_data", obs_res_in_data, 32'd5);
    req_valid = 2'b00;
    tick();
    tick();
    chk("single_rsp_valid", 32'(obs_rsp_valid), 32'h1);
    chk("single_rsp_data0", obs_rsp_data0, 32'd10);

    // Wrap-around doubling.
    req_valid = 2'b01; req_data0 = 32'h8000_0001;
    tick(); req_valid = 2'b00; tick(); tick();
    chk("wrap_rsp_data0", obs_rsp_data0, 32'h0000_0002);
    req_valid = 2'b10; req_data1 = 32'hFFFF_FFFF;
    tick(); req_valid = 2'b00; tick(); tick();
    chk("wrap_rsp_data1", obs_rsp_data1, 32'hFFFF_FFFE);

    // Contention, then reset mid-stream.
    req_valid = 2'b11; req_data0 = 32'd1; req_data1 = 32'd2;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (g_grant[0]) req_data0 += 2;
      if (g_grant[1]) req_data1 += 2;
    end
    reset = 1'b1;
    tick();
    chk("midrst_stall", 32'(obs_stall), 32'h3);
    chk("midrst_rsp_valid", 32'(obs_rsp_valid), 32'h0);
    chk("midrst_err", 32'(obs_err), 32'h0);
    tick();

    // After release: grants alternate 0,1,0,1 carrying data 1,2,3,4...
    reset = 1'b0; req_data0 = 32'd1; req_data1 = 32'd2;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("alt_grant", 32'(obs_res_in_valid), (k % 2 == 0) ? 32'h1 : 32'h2);
      chk("alt_data", obs_res_in_data, 32'(k + 1));
      if (g_grant[0]) req_data0 += 2;
      if (g_grant[1]) req_data1 += 2;
    end
    req_valid = 2'b00;
    tick(); tick(); tick();

    // Backpressure on requester 1.
    rsp_ready = 2'b01; req_valid = 2'b11; req_data0 = 32'd100; req_data1 = 32'd200;
    acc0 = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (obs_ready[0]) acc0++;
      if (g_grant[0]) req_data0 += 2;
      if (g_grant[1]) req_data1 += 2;
    end
    chk("bp_acc0_count", 32'(acc0), 32'd5);
    chk("bp_rsp_data1", obs_rsp_data1, 32'd400);
    chk("bp_stall1", 32'(obs_stall[1]), 32'h1);
    rsp_ready = 2'b11;
    tick();
    chk("bp_readmit", 32'(obs_ready), 32'h2);
    req_valid = 2'b00;
    tick(); tick(); tick();

    // Protocol error: stray tag with nothing in flight.
    res_out_valid = 2'b10; res_out_data = 32'hDEAD_BEEF;
    tick();
    tick();
    chk("perr_err", 32'(obs_err), 32'h1);
    chk("perr_rsp_valid", 32'(obs_rsp_valid), 32'h0);
    req_valid = 2'b01; req_data0 = 32'd7;
    tick(); req_valid = 2'b00; tick(); tick();
    chk("perr_sticky", 32'(obs_err), 32'h1);
    chk("perr_traffic_data", obs_rsp_data0, 32'd14);
    reset = 1'b1;
    tick();
    chk("perr_cleared", 32'(obs_err), 32'h0);
    reset = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
